// File: rtl/spi_pkg.sv
// Shared definitions for the SPI arbiter: FSM encoding, core STATUS bit positions
// and the default CONTROL byte.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_RD,
    S_ACK
  } state_t;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  localparam logic [7:0] CONTROL_VAL_DEF = 8'hE4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping
// to the lowest set request below ptr.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  logic          hi_v;
  logic [PW-1:0] hi_i;
  logic [PW-1:0] lo_i;

  // Scanning downward lets the lowest qualifying index overwrite earlier hits.
  always_comb begin
    hi_v  = 1'b0;
    hi_i  = '0;
    lo_i  = '0;
    valid = 1'b0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j]) begin
        valid = 1'b1;
        lo_i  = PW'(j);
        if (PW'(j) >= ptr) begin
          hi_v = 1'b1;
          hi_i = PW'(j);
        end
      end
    end
    idx = hi_v ? hi_i : lo_i;
    gnt = valid ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master core among N_REQ requesters, with
// per-byte WRITE/READ sequencing and a watchdog that aborts stalled transfers.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int         N_REQ       = 4,
  parameter logic [7:0] CONTROL_VAL = CONTROL_VAL_DEF,
  parameter int         TIMEOUT     = 255
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [N_REQ-1:0]   LAST,
  input  logic [8*N_REQ-1:0] TX_DATA,
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   BYTE_ACK,
  output logic [7:0]         RX_DATA,
  output logic               RX_VALID,
  output logic               ERR,
  output logic               SPI_WRITE,
  output logic               SPI_READ,
  output logic               SPI_CLR,
  output logic [7:0]         SPI_CONTROL,
  output logic [7:0]         SPI_DATA,
  input  logic [7:0]         SPI_RDATA,
  input  logic [7:0]         SPI_STATUS
);

  localparam int         PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    g_q, g_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       sd_q, sd_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_v;
  logic [7:0]       tx_sel;
  logic [PW-1:0]    ptr_nxt;
  logic             timeout;
  logic             status_unused;

  rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_v)
  );

  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (g_q == PW'(i)) tx_sel = TX_DATA[8*i +: 8];
    end
  end

  assign ptr_nxt       = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
  assign timeout       = (state_q == S_WAIT_START || state_q == S_WAIT_DONE) && (cnt_q == TO);
  assign status_unused = ^SPI_STATUS[7:2];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = '0;
    rx_d    = rx_q;
    sd_d    = sd_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_v) begin
          gnt_d   = pick_gnt;
          g_d     = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        sd_d    = tx_sel;
        last_d  = LAST[g_q];
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        cnt_d = cnt_q + 8'd1;
        if (SPI_STATUS[STATUS_BUSY]) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 8'd1;
        if (SPI_STATUS[STATUS_DONE]) state_d = S_RD;
      end
      S_RD: begin
        rx_d    = SPI_RDATA;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (last_q || !REQ[g_q]) begin
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog overrides any STATUS progress seen in the same cycle.
    if (timeout) begin
      err_d   = 1'b1;
      gnt_d   = '0;
      ptr_d   = ptr_nxt;
      cnt_d   = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      g_q     <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      rx_q    <= '0;
      sd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      sd_q    <= sd_d;
      err_q   <= err_d;
    end
  end

  // The LOAD byte is passed straight through so it lines up with the WRITE strobe.
  assign SPI_DATA    = (state_q == S_LOAD) ? tx_sel : sd_q;
  assign SPI_WRITE   = (state_q == S_LOAD);
  assign SPI_READ    = (state_q == S_RD);
  assign RX_VALID    = (state_q == S_ACK);
  assign BYTE_ACK    = (state_q == S_ACK) ? gnt_q : '0;
  assign RX_DATA     = rx_q;
  assign GNT         = gnt_q;
  assign ERR         = err_q;
  assign SPI_CLR     = err_q;
  assign SPI_CONTROL = (|gnt_q) ? CONTROL_VAL : 8'h00;

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench for spi_arbiter: directed requester scenarios against a
// behavioural SPI core that answers BUSY then DONE, or stalls on demand.
module tb_spi_arbiter;
  import spi_pkg::*;

  localparam logic [3:0] K_W = 4'd0;
  localparam logic [3:0] K_R = 4'd1;
  localparam logic [3:0] K_E = 4'd2;

  logic        clk;
  logic        CLR;
  logic [3:0]  REQ, LAST;
  logic [31:0] TX_DATA;
  logic [3:0]  GNT, BYTE_ACK;
  logic [7:0]  RX_DATA, SPI_CONTROL, SPI_DATA, SPI_RDATA, SPI_STATUS;
  logic        RX_VALID, ERR, SPI_WRITE, SPI_READ, SPI_CLR;

  typedef struct packed {
    logic [3:0] kind;
    logic [3:0] vec;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rsp_q[$];
  logic       core_stall;
  int         n_checks;
  int         n_errs;
  bit         done;

  spi_arbiter #(.N_REQ(4), .CONTROL_VAL(8'hE4), .TIMEOUT(16)) dut (
    .CLK(clk), .CLR(CLR), .REQ(REQ), .LAST(LAST), .TX_DATA(TX_DATA),
    .GNT(GNT), .BYTE_ACK(BYTE_ACK), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ERR(ERR), .SPI_WRITE(SPI_WRITE), .SPI_READ(SPI_READ), .SPI_CLR(SPI_CLR),
    .SPI_CONTROL(SPI_CONTROL), .SPI_DATA(SPI_DATA), .SPI_RDATA(SPI_RDATA),
    .SPI_STATUS(SPI_STATUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cyc_now();
    return int'($time / 10);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [3:0] kind, input logic [3:0] vec, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.vec  = vec;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mon(input string name, input logic [3:0] kind, input logic [3:0] vec, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected"}, {16'd0, kind, vec, data}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      chk(name, {16'd0, kind, vec, data}, {16'd0, e});
    end
  endtask

  // which: 0 = SPI_WRITE, 1 = RX_VALID, 2 = ERR
  task automatic wait_for(input int which, input string name, output int at);
    logic hit;
    at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      hit = (which == 0) ? SPI_WRITE : (which == 1) ? RX_VALID : ERR;
      if (hit) begin
        at = cyc_now();
        break;
      end
    end
    chk({name, "_seen"}, {31'd0, at >= 0}, 32'd1);
  endtask

  initial begin
    int w, a, a_prev, e_at, r_at;
    n_checks   = 0;
    n_errs     = 0;
    done       = 1'b0;
    core_stall = 1'b0;
    CLR        = 1'b1;
    REQ        = '0;
    LAST       = '0;
    TX_DATA    = '0;
    fork
      // Behavioural SPI core: BUSY the cycle after WRITE, then DONE, then idle.
      begin
        int ph;
        ph = 0;
        SPI_STATUS <= 8'h00;
        SPI_RDATA  <= 8'h00;
        while (!done) begin
          @(posedge clk);
          if (CLR) begin
            ph = 0;
            SPI_STATUS <= 8'h00;
          end else begin
            case (ph)
              0: if (SPI_WRITE && !core_stall) begin
                   SPI_STATUS <= 8'h01;
                   SPI_RDATA  <= (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
                   ph = 1;
                 end
              1: begin SPI_STATUS <= 8'h02; ph = 2; end
              default: begin SPI_STATUS <= 8'h00; ph = 0; end
            endcase
          end
        end
      end
      // Monitor
      begin
        while (!done) begin
          @(negedge clk);
          if (SPI_WRITE) begin
            mon("sb_write", K_W, GNT, SPI_DATA);
            chk("control_granted", {24'd0, SPI_CONTROL}, 32'hE4);
          end
          if (RX_VALID) mon("sb_rx", K_R, BYTE_ACK, RX_DATA);
          if (ERR) mon("sb_err", K_E, GNT, {6'd0, |BYTE_ACK, SPI_CLR});
        end
      end
      // Stimulus
      begin
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("rst_ptr", {30'd0, dut.ptr_q}, 32'd0);
        chk("rst_gnt", {28'd0, GNT}, 32'd0);
        chk("rst_pulses", {22'd0, BYTE_ACK, RX_VALID, ERR, SPI_WRITE, SPI_READ, SPI_CLR}, 32'd0);
        chk("rst_data", {8'd0, RX_DATA, SPI_DATA, SPI_CONTROL}, 32'd0);
        CLR = 1'b0;
        @(negedge clk);

        // Round robin with all four requesting one byte each: 0,1,2,3,0
        LAST    = 4'b1111;
        TX_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
          expect_ev(K_W, 4'(1 << (i % 4)), 8'hA0 + 8'(i % 4));
          expect_ev(K_R, 4'(1 << (i % 4)), 8'h10 + 8'(i));
          rsp_q.push_back(8'h10 + 8'(i));
        end
        REQ    = 4'b1111;
        a_prev = cyc_now();
        for (int i = 0; i < 5; i++) begin
          wait_for(0, "rr_write", w);
          chk(i == 0 ? "rr_first_latency" : "rr_idle_gap", 32'(w - a_prev), i == 0 ? 32'd1 : 32'd2);
          wait_for(1, "rr_rx", a_prev);
          if (i == 4) REQ = 4'b0000;
        end
        @(negedge clk);
        chk("rr_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // Single requester 0, two bytes with loopback responses
        LAST    = 4'b0000;
        TX_DATA = 32'h0000_0050;
        expect_ev(K_W, 4'b0001, 8'h50);
        expect_ev(K_R, 4'b0001, 8'h4D);
        expect_ev(K_W, 4'b0001, 8'h54);
        expect_ev(K_R, 4'b0001, 8'h6C);
        rsp_q.push_back(8'h4D);
        rsp_q.push_back(8'h6C);
        REQ = 4'b0001;
        wait_for(0, "two_write0", w);
        wait_for(1, "two_rx0", a);
        chk("two_byte_time", 32'(a - w), 32'd4);
        TX_DATA[7:0] = 8'h54;
        LAST[0]      = 1'b1;
        wait_for(0, "two_write1", w);
        chk("two_next_byte_gap", 32'(w - a), 32'd1);
        wait_for(1, "two_rx1", a);
        REQ = 4'b0000;
        @(negedge clk);
        chk("two_gnt_released", {28'd0, GNT}, 32'd0);
        chk("two_ptr", {30'd0, dut.ptr_q}, 32'd1);

        // Stalled core: requester 1 times out, requester 2 is next
        core_stall = 1'b1;
        LAST       = 4'b0010;
        TX_DATA    = {8'h00, 8'h77, 8'h11, 8'h00};
        expect_ev(K_W, 4'b0010, 8'h11);
        expect_ev(K_E, 4'b0000, 8'h01);
        expect_ev(K_W, 4'b0100, 8'h77);
        expect_ev(K_R, 4'b0100, 8'h5A);
        rsp_q.push_back(8'h5A);
        REQ = 4'b0110;
        wait_for(0, "to_write", w);
        wait_for(2, "to_err", e_at);
        chk("to_abort_delay", 32'(e_at - w), 32'd18);
        REQ        = 4'b0100;
        core_stall = 1'b0;

        // Requester 2 drops REQ during WAIT_DONE of a non-LAST byte
        wait_for(0, "drop_write", w);
        chk("drop_after_abort_gap", 32'(w - e_at), 32'd1);
        repeat (2) @(negedge clk);
        chk("drop_in_wait_done", 32'(dut.state_q), 32'(S_WAIT_DONE));
        REQ = 4'b0000;
        wait_for(1, "drop_rx", a);
        chk("drop_rx_time", 32'(a - w), 32'd4);
        @(negedge clk);
        chk("drop_gnt_released", {28'd0, GNT}, 32'd0);
        chk("drop_ptr", {30'd0, dut.ptr_q}, 32'd3);

        // CLR in WAIT_DONE, then a fresh grant searched from 0
        LAST    = 4'b0001;
        TX_DATA = 32'h0000_0033;
        expect_ev(K_W, 4'b0001, 8'h33);
        rsp_q.push_back(8'hEE);
        REQ = 4'b0001;
        wait_for(0, "clr_write", w);
        repeat (2) @(negedge clk);
        chk("clr_in_wait_done", 32'(dut.state_q), 32'(S_WAIT_DONE));
        CLR = 1'b1;
        REQ = 4'b0000;
        @(negedge clk);
        chk("clr_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("clr_ptr", {30'd0, dut.ptr_q}, 32'd0);
        chk("clr_gnt_pulses", {18'd0, GNT, BYTE_ACK, RX_VALID, ERR, SPI_WRITE, SPI_READ, SPI_CLR}, 32'd0);
        chk("clr_data", {8'd0, RX_DATA, SPI_DATA, SPI_CONTROL}, 32'd0);
        CLR     = 1'b0;
        LAST    = 4'b1000;
        TX_DATA = 32'h9900_0000;
        expect_ev(K_W, 4'b1000, 8'h99);
        expect_ev(K_R, 4'b1000, 8'hC3);
        rsp_q.push_back(8'hC3);
        REQ  = 4'b1000;
        r_at = cyc_now();
        @(negedge clk);
        chk("post_clr_grant", {27'd0, SPI_WRITE, GNT}, 32'h18);
        chk("post_clr_latency", 32'(cyc_now() - r_at), 32'd1);
        wait_for(1, "post_clr_rx", a);
        REQ = 4'b0000;
        @(negedge clk);
        chk("post_clr_release", {28'd0, GNT}, 32'd0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
